reorder_buffer: RTL and testbench

Circular reorder buffer for the Tomasulo core.
- Allocates one entry per issued instruction and tags it with its ROB index.
- Captures results from the common data bus and serves operand bypass queries from issue.
- Retires in order, driving the register-file unlock interface (unlock/unlock_rd/unlock_robpos/unlock_val).
- Raises clear plus a redirect PC when a mispredicted branch retires.

---
 rtl/reorder_buffer_pkg.sv | 26 ++
 rtl/reorder_buffer_bypass.sv | 32 +++
 rtl/reorder_buffer.sv | 191 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, entry payload layout and helpers for the reorder buffer.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 32;
    localparam int ROB_W    = $clog2(ROB_SIZE);
    localparam int XLEN     = 32;
    localparam int REG_W    = 5;

    localparam logic [ROB_W:0] FULL_COUNT = (ROB_W + 1)'(ROB_SIZE);

    // Per-entry payload; busy/done live in separate vectors so they can be cleared in bulk.
    typedef struct packed {
        logic             has_rd;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  val;
        logic             is_branch;
        logic             pred;
        logic             taken;
        logic [XLEN-1:0]  alt_pc;
    } rob_payload_t;

    function automatic logic is_mispredict(input logic is_branch, input logic pred, input logic taken);
        return is_branch & (pred ^ taken);
    endfunction

endpackage

// File: rtl/reorder_buffer_bypass.sv
// Operand lookup for one issue query port: stored result first, then the live CDB value.
module reorder_buffer_bypass
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_W-1:0]         q_robpos,
    input  logic [ROB_SIZE-1:0]      busy_vec,
    input  logic [ROB_SIZE-1:0]      done_vec,
    input  logic [ROB_SIZE*XLEN-1:0] val_vec,
    input  logic                     wb_valid,
    input  logic [ROB_W-1:0]         wb_robpos,
    input  logic [XLEN-1:0]          wb_val,
    output logic                     q_ready,
    output logic [XLEN-1:0]          q_val
);

    // Stored result wins; otherwise forward a broadcast aimed at the queried entry.
    always_comb begin
        q_ready = 1'b0;
        q_val   = '0;
        if (busy_vec[q_robpos] && done_vec[q_robpos]) begin
            q_ready = 1'b1;
            q_val   = val_vec[q_robpos*XLEN +: XLEN];
        end else if (wb_valid && (wb_robpos == q_robpos) && busy_vec[q_robpos]) begin
            q_ready = 1'b1;
            q_val   = wb_val;
        end else begin
            q_ready = 1'b0;
            q_val   = '0;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order completion from the CDB,
// in-order retire with register unlock and flush on a mispredicted branch.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic             issue_valid,
    input  logic             issue_has_rd,
    input  logic [4:0]       issue_rd,
    input  logic             issue_is_branch,
    input  logic             issue_pred_taken,
    input  logic [XLEN-1:0]  issue_alt_pc,
    output logic [ROB_W-1:0] alloc_robpos,
    output logic             rob_full,
    input  logic             wb_valid,
    input  logic [ROB_W-1:0] wb_robpos,
    input  logic [XLEN-1:0]  wb_val,
    input  logic             wb_taken,
    input  logic [ROB_W-1:0] q1_robpos,
    input  logic [ROB_W-1:0] q2_robpos,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [XLEN-1:0]  q1_val,
    output logic [XLEN-1:0]  q2_val,
    output logic             unlock,
    output logic [4:0]       unlock_rd,
    output logic [ROB_W-1:0] unlock_robpos,
    output logic [XLEN-1:0]  unlock_val,
    output logic             clear,
    output logic [XLEN-1:0]  redirect_pc
);

    logic [ROB_W-1:0]    head_q, head_d;
    logic [ROB_W-1:0]    tail_q, tail_d;
    logic [ROB_W:0]      count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] done_q, done_d;
    rob_payload_t        data_q [ROB_SIZE];
    rob_payload_t        data_d [ROB_SIZE];

    rob_payload_t             head_e_s;
    logic                     rob_full_s;
    logic                     commit_s;
    logic                     clear_s;
    logic                     unlock_s;
    logic                     issue_s;
    logic                     wb_hit_s;
    logic [ROB_SIZE*XLEN-1:0] val_flat_s;

    // Retire and allocate decisions; the reset cycle never retires.
    always_comb begin
        head_e_s   = data_q[head_q];
        rob_full_s = (count_q == FULL_COUNT);
        commit_s   = ready & ~reset & busy_q[head_q] & done_q[head_q];
        clear_s    = commit_s & is_mispredict(head_e_s.is_branch, head_e_s.pred, head_e_s.taken);
        unlock_s   = commit_s & head_e_s.has_rd;
        issue_s    = ready & issue_valid & ~rob_full_s;
        wb_hit_s   = ready & wb_valid & busy_q[wb_robpos];
    end

    // Retire-side outputs read zero unless the matching event fires.
    always_comb begin
        alloc_robpos  = tail_q;
        rob_full      = rob_full_s;
        unlock        = unlock_s;
        clear         = clear_s;
        unlock_rd     = 5'd0;
        unlock_robpos = '0;
        unlock_val    = '0;
        redirect_pc   = '0;
        if (unlock_s) begin
            unlock_rd     = head_e_s.rd;
            unlock_robpos = head_q;
            unlock_val    = head_e_s.val;
        end else begin
            unlock_rd     = 5'd0;
            unlock_robpos = '0;
            unlock_val    = '0;
        end
        if (clear_s) begin
            redirect_pc = head_e_s.alt_pc;
        end else begin
            redirect_pc = '0;
        end
    end

    // Flatten stored results so each query port sees the whole value array.
    always_comb begin
        val_flat_s = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
            val_flat_s[i*XLEN +: XLEN] = data_q[i].val;
        end
    end

    reorder_buffer_bypass u_bypass_q1 (
        .q_robpos (q1_robpos),
        .busy_vec (busy_q),
        .done_vec (done_q),
        .val_vec  (val_flat_s),
        .wb_valid (wb_valid),
        .wb_robpos(wb_robpos),
        .wb_val   (wb_val),
        .q_ready  (q1_ready),
        .q_val    (q1_val)
    );

    reorder_buffer_bypass u_bypass_q2 (
        .q_robpos (q2_robpos),
        .busy_vec (busy_q),
        .done_vec (done_q),
        .val_vec  (val_flat_s),
        .wb_valid (wb_valid),
        .wb_robpos(wb_robpos),
        .wb_val   (wb_val),
        .q_ready  (q2_ready),
        .q_val    (q2_val)
    );

    // Next state: a flush overrides everything issued or written back in the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;
        data_d  = data_q;
        if (clear_s) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
            done_d  = '0;
        end else begin
            if (wb_hit_s) begin
                done_d[wb_robpos]       = 1'b1;
                data_d[wb_robpos].val   = wb_val;
                data_d[wb_robpos].taken = wb_taken;
            end else begin
                done_d = done_q;
            end
            if (commit_s) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + (ROB_W)'(1);
            end else begin
                head_d = head_q;
            end
            // A full buffer blocks issue, so the tail slot can never be the retiring head.
            if (issue_s) begin
                busy_d[tail_q] = 1'b1;
                done_d[tail_q] = 1'b0;
                data_d[tail_q] = '{has_rd:    issue_has_rd,
                                   rd:        issue_rd,
                                   val:       '0,
                                   is_branch: issue_is_branch,
                                   pred:      issue_pred_taken,
                                   taken:     1'b0,
                                   alt_pc:    issue_alt_pc};
                tail_d         = tail_q + (ROB_W)'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + (ROB_W + 1)'(issue_s) - (ROB_W + 1)'(commit_s);
        end
    end

    // Pointer and status state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Payload storage is qualified by busy/done and needs no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset, ready, issue_valid, issue_has_rd, issue_is_branch, issue_pred_taken;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc;
    logic [4:0]  alloc_robpos;
    logic        rob_full;
    logic        wb_valid, wb_taken;
    logic [4:0]  wb_robpos;
    logic [31:0] wb_val;
    logic [4:0]  q1_robpos, q2_robpos;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        unlock, clear;
    logic [4:0]  unlock_rd, unlock_robpos;
    logic [31:0] unlock_val, redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .reset(reset), .ready(ready),
        .issue_valid(issue_valid), .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .issue_is_branch(issue_is_branch), .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .alloc_robpos(alloc_robpos), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_robpos(wb_robpos), .wb_val(wb_val), .wb_taken(wb_taken),
        .q1_robpos(q1_robpos), .q2_robpos(q2_robpos),
        .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_val(q1_val), .q2_val(q2_val),
        .unlock(unlock), .unlock_rd(unlock_rd), .unlock_robpos(unlock_robpos), .unlock_val(unlock_val),
        .clear(clear), .redirect_pc(redirect_pc)
    );

    // Reference model: in-flight instructions in program order, oldest first.
    typedef struct {
        int        idx;
        bit        has_rd;
        bit [4:0]  rd;
        bit        done;
        bit [31:0] val;
        bit        br;
        bit        pred;
        bit        taken;
        bit [31:0] alt;
    } ent_t;

    ent_t mq[$];
    int   m_tail = 0;

    function automatic int find_ent(input int idx);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].idx == idx) return i;
        end
        return -1;
    endfunction

    function automatic void query_exp(input logic [4:0] qp, output logic rdy, output logic [31:0] v);
        int k;
        k = find_ent(int'(qp));
        rdy = 1'b0;
        v   = 32'd0;
        if (k >= 0 && mq[k].done) begin
            rdy = 1'b1;
            v   = mq[k].val;
        end else if (k >= 0 && wb_valid && wb_robpos == qp) begin
            rdy = 1'b1;
            v   = wb_val;
        end
    endfunction

    task automatic set_idle();
        reset = 1'b0; ready = 1'b1; issue_valid = 1'b0; issue_has_rd = 1'b0; issue_rd = 5'd0;
        issue_is_branch = 1'b0; issue_pred_taken = 1'b0; issue_alt_pc = 32'd0;
        wb_valid = 1'b0; wb_robpos = 5'd0; wb_val = 32'd0; wb_taken = 1'b0;
        q1_robpos = 5'd0; q2_robpos = 5'd0;
    endtask

    task automatic drive_issue(input logic has_rd, input logic [4:0] rd, input logic br,
                               input logic pred, input logic [31:0] alt);
        issue_valid = 1'b1; issue_has_rd = has_rd; issue_rd = rd;
        issue_is_branch = br; issue_pred_taken = pred; issue_alt_pc = alt;
    endtask

    // One clock: compare every output with the model, take the edge, then advance the model.
    task automatic tick();
        logic e_commit, e_clear, e_unlock, e_full, e_q1r, e_q2r;
        logic [4:0]  e_rd, e_pos;
        logic [31:0] e_uval, e_redir, e_q1v, e_q2v;
        logic c_reset, c_ready, c_issue, c_has_rd, c_br, c_pred, c_wb, c_taken;
        logic [4:0]  c_rd, c_wbpos;
        logic [31:0] c_alt, c_wbval;
        int sz, k;
        ent_t ne;
        #1;
        e_full   = (mq.size() == 32);
        e_commit = ready && !reset && mq.size() > 0 && mq[0].done;
        e_clear  = e_commit && mq[0].br && (mq[0].taken != mq[0].pred);
        e_unlock = e_commit && mq[0].has_rd;
        e_rd     = e_unlock ? mq[0].rd : 5'd0;
        e_pos    = e_unlock ? 5'(mq[0].idx) : 5'd0;
        e_uval   = e_unlock ? mq[0].val : 32'd0;
        e_redir  = e_clear ? mq[0].alt : 32'd0;
        query_exp(q1_robpos, e_q1r, e_q1v);
        query_exp(q2_robpos, e_q2r, e_q2v);
        checks++; if (alloc_robpos !== 5'(m_tail)) begin errors++; $display("FAIL alloc_robpos got %0d exp %0d t=%0t", alloc_robpos, m_tail, $time); end
        checks++; if (rob_full !== e_full) begin errors++; $display("FAIL rob_full got %b exp %b t=%0t", rob_full, e_full, $time); end
        checks++; if (unlock !== e_unlock) begin errors++; $display("FAIL unlock got %b exp %b t=%0t", unlock, e_unlock, $time); end
        checks++; if (unlock_rd !== e_rd) begin errors++; $display("FAIL unlock_rd got %0d exp %0d t=%0t", unlock_rd, e_rd, $time); end
        checks++; if (unlock_robpos !== e_pos) begin errors++; $display("FAIL unlock_robpos got %0d exp %0d t=%0t", unlock_robpos, e_pos, $time); end
        checks++; if (unlock_val !== e_uval) begin errors++; $display("FAIL unlock_val got %h exp %h t=%0t", unlock_val, e_uval, $time); end
        checks++; if (clear !== e_clear) begin errors++; $display("FAIL clear got %b exp %b t=%0t", clear, e_clear, $time); end
        checks++; if (redirect_pc !== e_redir) begin errors++; $display("FAIL redirect_pc got %h exp %h t=%0t", redirect_pc, e_redir, $time); end
        checks++; if (q1_ready !== e_q1r) begin errors++; $display("FAIL q1_ready got %b exp %b t=%0t", q1_ready, e_q1r, $time); end
        checks++; if (q1_val !== e_q1v) begin errors++; $display("FAIL q1_val got %h exp %h t=%0t", q1_val, e_q1v, $time); end
        checks++; if (q2_ready !== e_q2r) begin errors++; $display("FAIL q2_ready got %b exp %b t=%0t", q2_ready, e_q2r, $time); end
        checks++; if (q2_val !== e_q2v) begin errors++; $display("FAIL q2_val got %h exp %h t=%0t", q2_val, e_q2v, $time); end
        c_reset = reset; c_ready = ready; c_issue = issue_valid; c_has_rd = issue_has_rd; c_rd = issue_rd;
        c_br = issue_is_branch; c_pred = issue_pred_taken; c_alt = issue_alt_pc;
        c_wb = wb_valid; c_wbpos = wb_robpos; c_wbval = wb_val; c_taken = wb_taken;
        @(posedge clk);
        #1;
        if (c_reset) begin
            mq.delete();
            m_tail = 0;
        end else if (c_ready) begin
            if (e_clear) begin
                mq.delete();
                m_tail = 0;
            end else begin
                sz = mq.size();
                if (c_wb) begin
                    k = find_ent(int'(c_wbpos));
                    if (k >= 0) begin
                        mq[k].done = 1'b1; mq[k].val = c_wbval; mq[k].taken = c_taken;
                    end
                end
                if (e_commit) void'(mq.pop_front());
                if (c_issue && sz < 32) begin
                    ne = '{idx: m_tail, has_rd: c_has_rd, rd: c_rd, done: 1'b0, val: 32'd0,
                           br: c_br, pred: c_pred, taken: 1'b0, alt: c_alt};
                    mq.push_back(ne);
                    m_tail = (m_tail + 1) % 32;
                end
            end
        end
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        set_idle();
        #1;
        checks++; if (alloc_robpos !== 5'd0) begin errors++; $display("FAIL reset_alloc got %0d exp 0", alloc_robpos); end
        checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", rob_full); end
        checks++; if (unlock !== 1'b0 || clear !== 1'b0) begin errors++; $display("FAIL reset_unlock_clear got %b%b exp 00", unlock, clear); end
        checks++; if (q1_ready !== 1'b0 || q1_val !== 32'd0) begin errors++; $display("FAIL reset_q1 got %b/%h exp 0/0", q1_ready, q1_val); end
        checks++; if (unlock_val !== 32'd0 || redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", unlock_val, redirect_pc); end
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        set_idle(); drive_issue(1'b1, 5'd5, 1'b0, 1'b0, 32'd0);
        #1;
        checks++; if (alloc_robpos !== 5'd0) begin errors++; $display("FAIL basic_alloc0 got %0d exp 0", alloc_robpos); end
        tick();
        set_idle(); wb_valid = 1'b1; wb_robpos = 5'd0; wb_val = 32'h1234;
        #1;
        checks++; if (alloc_robpos !== 5'd1) begin errors++; $display("FAIL basic_alloc1 got %0d exp 1", alloc_robpos); end
        checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL basic_no_same_cycle_commit got %b exp 0", unlock); end
        tick();
        set_idle();
        #1;
        checks++; if (unlock !== 1'b1 || unlock_rd !== 5'd5 || unlock_robpos !== 5'd0 || unlock_val !== 32'h1234) begin
            errors++; $display("FAIL basic_unlock got %b/%0d/%0d/%h exp 1/5/0/1234", unlock, unlock_rd, unlock_robpos, unlock_val);
        end
        tick();
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            set_idle(); drive_issue(1'b1, 5'(i), 1'b0, 1'b0, 32'd0);
            tick();
        end
        #1;
        checks++; if (rob_full !== 1'b1 || alloc_robpos !== 5'd0) begin errors++; $display("FAIL fill_full got %b/%0d exp 1/0", rob_full, alloc_robpos); end
        tick();
        set_idle(); wb_valid = 1'b1; wb_robpos = 5'd0; wb_val = 32'hABCD;
        #1;
        checks++; if (alloc_robpos !== 5'd0) begin errors++; $display("FAIL fill_33rd_ignored got %0d exp 0", alloc_robpos); end
        tick();
        set_idle(); drive_issue(1'b1, 5'd9, 1'b0, 1'b0, 32'd0);
        #1;
        checks++; if (unlock !== 1'b1 || rob_full !== 1'b1) begin errors++; $display("FAIL fill_commit_while_full got %b/%b exp 1/1", unlock, rob_full); end
        tick();
        set_idle();
        #1;
        checks++; if (rob_full !== 1'b0 || alloc_robpos !== 5'd0) begin errors++; $display("FAIL fill_drop got %b/%0d exp 0/0", rob_full, alloc_robpos); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            set_idle(); drive_issue(1'b1, 5'(i % 32), 1'b0, 1'b0, 32'd0);
            #1;
            checks++; if (alloc_robpos !== 5'(i % 32)) begin errors++; $display("FAIL wrap_alloc got %0d exp %0d", alloc_robpos, i % 32); end
            tick();
            set_idle(); wb_valid = 1'b1; wb_robpos = 5'(i % 32); wb_val = 32'(i);
            tick();
            set_idle();
            #1;
            checks++; if (unlock !== 1'b1 || unlock_robpos !== 5'(i % 32)) begin errors++; $display("FAIL wrap_order got %b/%0d exp 1/%0d", unlock, unlock_robpos, i % 32); end
            tick();
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        set_idle(); drive_issue(1'b1, 5'd1, 1'b0, 1'b0, 32'd0); tick();
        set_idle(); drive_issue(1'b1, 5'd2, 1'b0, 1'b0, 32'd0); tick();
        set_idle(); wb_valid = 1'b1; wb_robpos = 5'd1; wb_val = 32'hAA; tick();
        set_idle();
        #1;
        checks++; if (unlock !== 1'b0) begin errors++; $display("FAIL ooo_blocked got %b exp 0", unlock); end
        tick();
        set_idle(); wb_valid = 1'b1; wb_robpos = 5'd0; wb_val = 32'hBB; tick();
        set_idle();
        #1;
        checks++; if (unlock !== 1'b1 || unlock_robpos !== 5'd0 || unlock_val !== 32'hBB) begin errors++; $display("FAIL ooo_first got %b/%0d/%h exp 1/0/bb", unlock, unlock_robpos, unlock_val); end
        tick();
        #1;
        checks++; if (unlock !== 1'b1 || unlock_robpos !== 5'd1 || unlock_val !== 32'hAA) begin errors++; $display("FAIL ooo_second got %b/%0d/%h exp 1/1/aa", unlock, unlock_robpos, unlock_val); end
        tick();
    endtask

    task automatic test_mispredict();
        do_reset();
        set_idle(); drive_issue(1'b0, 5'd0, 1'b1, 1'b1, 32'h100); tick();
        set_idle(); drive_issue(1'b1, 5'd7, 1'b0, 1'b0, 32'd0); tick();
        set_idle(); drive_issue(1'b1, 5'd8, 1'b0, 1'b0, 32'd0); tick();
        set_idle(); wb_valid = 1'b1; wb_robpos = 5'd0; wb_taken = 1'b0; tick();
        set_idle(); drive_issue(1'b1, 5'd9, 1'b0, 1'b0, 32'd0);
        wb_valid = 1'b1; wb_robpos = 5'd1; wb_val = 32'h55;
        #1;
        checks++; if (clear !== 1'b1 || redirect_pc !== 32'h100 || unlock !== 1'b0) begin errors++; $display("FAIL mispredict_clear got %b/%h/%b exp 1/100/0", clear, redirect_pc, unlock); end
        tick();
        set_idle(); q1_robpos = 5'd1;
        #1;
        checks++; if (alloc_robpos !== 5'd0 || rob_full !== 1'b0 || clear !== 1'b0) begin errors++; $display("FAIL mispredict_empty got %0d/%b/%b exp 0/0/0", alloc_robpos, rob_full, clear); end
        checks++; if (q1_ready !== 1'b0) begin errors++; $display("FAIL mispredict_younger_gone got %b exp 0", q1_ready); end
        tick();
    endtask

    task automatic test_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_idle(); drive_issue(1'b1, 5'(i + 10), 1'b0, 1'b0, 32'd0); tick();
        end
        set_idle(); q1_robpos = 5'd3; wb_valid = 1'b1; wb_robpos = 5'd3; wb_val = 32'h77;
        #1;
        checks++; if (q1_ready !== 1'b1 || q1_val !== 32'h77) begin errors++; $display("FAIL bypass_forward got %b/%h exp 1/77", q1_ready, q1_val); end
        tick();
        set_idle(); q1_robpos = 5'd3; q2_robpos = 5'd2;
        #1;
        checks++; if (q1_ready !== 1'b1 || q1_val !== 32'h77) begin errors++; $display("FAIL bypass_stored got %b/%h exp 1/77", q1_ready, q1_val); end
        checks++; if (q2_ready !== 1'b0 || q2_val !== 32'd0) begin errors++; $display("FAIL bypass_pending got %b/%h exp 0/0", q2_ready, q2_val); end
        tick();
        set_idle(); wb_valid = 1'b1; wb_robpos = 5'd0; wb_val = 32'h99; tick();
        set_idle(); ready = 1'b0; q1_robpos = 5'd0;
        #1;
        checks++; if (unlock !== 1'b0 || q1_ready !== 1'b1 || q1_val !== 32'h99) begin errors++; $display("FAIL bypass_frozen got %b/%b/%h exp 0/1/99", unlock, q1_ready, q1_val); end
        tick();
        set_idle();
        #1;
        checks++; if (unlock !== 1'b1 || unlock_robpos !== 5'd0 || alloc_robpos !== 5'd4) begin errors++; $display("FAIL bypass_resume got %b/%0d/%0d exp 1/0/4", unlock, unlock_robpos, alloc_robpos); end
        tick();
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int c = 0; c < 900; c++) begin
            set_idle();
            reset = ($urandom_range(0, 99) == 0);
            ready = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 4) == 0)
                    drive_issue(1'b0, 5'd0, 1'b1, 1'($urandom), $urandom);
                else
                    drive_issue(1'($urandom), 5'($urandom), 1'b0, 1'b0, 32'd0);
            end
            n = mq.size();
            wb_valid = ($urandom_range(0, 9) < 6);
            wb_robpos = (n > 0 && $urandom_range(0, 3) != 0) ? 5'(mq[$urandom_range(0, n - 1)].idx) : 5'($urandom);
            wb_val = $urandom;
            wb_taken = 1'($urandom);
            q1_robpos = (n > 0 && $urandom_range(0, 1) == 1) ? 5'(mq[$urandom_range(0, n - 1)].idx) : 5'($urandom);
            q2_robpos = ($urandom_range(0, 2) == 0) ? wb_robpos : 5'($urandom);
            tick();
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_out_of_order();
        test_mispredict();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
